// File: rtl/telem_readout_if.sv
// Read-port and byte-stream signals between the telemetry readout and its
// neighbours: the target store read port and the downlink byte sink.
interface telem_readout_if #(
  parameter int SLOT_W  = 5,
  parameter int COORD_W = 8
);
  logic                 rd_en;
  logic [SLOT_W-1:0]    rd_addr;
  logic [4*COORD_W-1:0] rd_data;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output rd_en, rd_addr, tx_data, tx_valid,
    input  rd_data, tx_ready
  );

  modport slave (
    input  rd_en, rd_addr, tx_data, tx_valid,
    output rd_data, tx_ready
  );
endinterface

// File: rtl/telem_readout.sv
// Telemetry store readout: scans occupied slots in ascending order, fetches each
// record and streams it as bytes. Define TELEM_CKSUM_EN to append an XOR checksum byte.
module telem_readout #(
  parameter int NUM_SLOTS = 32,
  parameter int SLOT_W    = 5,
  parameter int COORD_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_SLOTS-1:0] slot_mask,
  output logic                 busy,
  output logic                 done,
  telem_readout_if.master      bus
);
  localparam int REC_W = 4 * COORD_W;
`ifdef TELEM_CKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd5;
`else
  localparam logic [2:0] LAST_IDX = 3'd4;
`endif
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

  typedef enum logic [2:0] {IDLE, SCAN, FETCH, WAIT, SEND, FIN} state_t;

  state_t               state_reg, state_next;
  logic [NUM_SLOTS-1:0] mask_reg, mask_next;
  logic [SLOT_W-1:0]    cnt_reg, cnt_next;
  logic [REC_W-1:0]     rec_reg, rec_next;
  logic [2:0]           idx_reg, idx_next;
  logic [7:0]           tx_data_reg, tx_data_next;
  logic                 tx_valid_reg, tx_valid_next;

  logic [7:0] slot_byte;
  logic [7:0] field_byte [4];
  logic [7:0] next_byte;

  assign slot_byte = 8'(cnt_reg);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_field
      assign field_byte[gi] = 8'(rec_reg[gi*COORD_W +: COORD_W]);
    end
  endgenerate

`ifdef TELEM_CKSUM_EN
  logic [7:0] cksum;
  assign cksum = slot_byte ^ field_byte[0] ^ field_byte[1] ^ field_byte[2] ^ field_byte[3];
`endif

  // Byte that follows the one currently presented (idx_reg)
  always_comb begin
    next_byte = 8'h00;
    case (idx_reg)
      3'd0:    next_byte = field_byte[0];
      3'd1:    next_byte = field_byte[1];
      3'd2:    next_byte = field_byte[2];
      3'd3:    next_byte = field_byte[3];
`ifdef TELEM_CKSUM_EN
      3'd4:    next_byte = cksum;
`endif
      default: next_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    mask_next     = mask_reg;
    cnt_next      = cnt_reg;
    rec_next      = rec_reg;
    idx_next      = idx_reg;
    tx_data_next  = tx_data_reg;
    tx_valid_next = tx_valid_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          mask_next  = slot_mask;
          cnt_next   = '0;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (mask_reg[cnt_reg])        state_next = FETCH;
        else if (cnt_reg == LAST_SLOT) state_next = FIN;
        else                           cnt_next   = cnt_reg + 1'b1;
      end
      FETCH: state_next = WAIT;
      WAIT: begin
        // Store data is valid only now; the slot byte is presented next cycle
        rec_next      = bus.rd_data;
        idx_next      = 3'd0;
        tx_data_next  = slot_byte;
        tx_valid_next = 1'b1;
        state_next    = SEND;
      end
      SEND: begin
        if (tx_valid_reg && bus.tx_ready) begin
          if (idx_reg == LAST_IDX) begin
            tx_valid_next = 1'b0;
            tx_data_next  = 8'h00;
            if (cnt_reg == LAST_SLOT) begin
              state_next = FIN;
            end else begin
              cnt_next   = cnt_reg + 1'b1;
              state_next = SCAN;
            end
          end else begin
            idx_next     = idx_reg + 1'b1;
            tx_data_next = next_byte;
          end
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      mask_reg     <= '0;
      cnt_reg      <= '0;
      rec_reg      <= '0;
      idx_reg      <= '0;
      tx_data_reg  <= '0;
      tx_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mask_reg     <= mask_next;
      cnt_reg      <= cnt_next;
      rec_reg      <= rec_next;
      idx_reg      <= idx_next;
      tx_data_reg  <= tx_data_next;
      tx_valid_reg <= tx_valid_next;
    end
  end

  assign bus.rd_en    = (state_reg == FETCH);
  assign bus.rd_addr  = cnt_reg;
  assign bus.tx_data  = tx_data_reg;
  assign bus.tx_valid = tx_valid_reg;
  assign busy         = (state_reg != IDLE) && (state_reg != FIN);
  assign done         = (state_reg == FIN);
endmodule

// File: tb/tb_telem_readout.sv
// Bench for telem_readout: a frame-level model of the dump (queues of expected
// read addresses and bytes) checked every cycle; honours TELEM_CKSUM_EN.
module tb_telem_readout;
  localparam int NUM_SLOTS = 32;
`ifdef TELEM_CKSUM_EN
  localparam int NB = 6;
`else
  localparam int NB = 5;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] slot_mask;
  logic        busy;
  logic        done;

  telem_readout_if #(.SLOT_W(5), .COORD_W(8)) bus ();

  telem_readout #(.NUM_SLOTS(32), .SLOT_W(5), .COORD_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .slot_mask(slot_mask),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int done_seen = 0;

  logic [31:0] store_mem [NUM_SLOTS];
  logic [7:0]  exp_bytes [$];
  logic [4:0]  exp_addr  [$];
  logic [7:0]  got_bytes [$];
  logic [4:0]  got_addr  [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic note_fail(input string name, input logic [31:0] got);
    total++;
    bad++;
    $display("FAIL %s: got %0h want none", name, got);
  endtask

  // Synchronous read port of the store; garbage whenever not strobed
  always @(posedge clk)
    bus.rd_data <= bus.rd_en ? store_mem[bus.rd_addr] : $urandom;

  // Expected frames straight from the mask and store contents
  function automatic void build_model(input logic [31:0] mask);
    logic [7:0] b [6];
    logic [31:0] r;
    exp_bytes.delete();
    exp_addr.delete();
    got_bytes.delete();
    got_addr.delete();
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (mask[s]) begin
        r = store_mem[s];
        b[0] = 8'(s);
        b[1] = r[7:0];
        b[2] = r[15:8];
        b[3] = r[23:16];
        b[4] = r[31:24];
        b[5] = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4];
        exp_addr.push_back(5'(s));
        for (int i = 0; i < NB; i++) exp_bytes.push_back(b[i]);
      end
    end
  endfunction

  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        check("hold_valid", bus.tx_valid, 1'b1);
        check("hold_data", bus.tx_data, prev_data);
      end
      if (bus.tx_valid && bus.tx_ready) begin
        got_bytes.push_back(bus.tx_data);
        if (exp_bytes.size() == 0) note_fail("extra_byte", bus.tx_data);
        else check("tx_byte", bus.tx_data, exp_bytes.pop_front());
      end
      if (bus.rd_en) begin
        got_addr.push_back(bus.rd_addr);
        if (exp_addr.size() == 0) note_fail("extra_rd", bus.rd_addr);
        else check("rd_addr", bus.rd_addr, exp_addr.pop_front());
      end
      if (done) done_seen++;
      prev_valid = bus.tx_valid;
      prev_ready = bus.tx_ready;
      prev_data  = bus.tx_data;
    end
  end

  function automatic logic pick_ready(input int mode);
    return (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  endfunction

  // One full dump. mode 0: tx_ready held high (done cycle is then checked
  // against 1 + 32 + occupied*(2+NB)); mode 1: random backpressure.
  task automatic run_dump(input logic [31:0] mask, input int mode,
                          input bit busy_start, input bit fin_start, output int done_cyc);
    int c, exp_done, d0;
    bit seen, injected;
    build_model(mask);
    d0 = done_seen;
    exp_done = 1 + NUM_SLOTS + $countones(mask) * (2 + NB);
    done_cyc = -1;
    @(posedge clk); #1;
    start = 1'b1; slot_mask = mask; bus.tx_ready = pick_ready(mode);
    @(posedge clk); #1;
    start = 1'b0; slot_mask = $urandom; bus.tx_ready = pick_ready(mode);
    c = 1; seen = 1'b0; injected = 1'b0;
    while (!seen && c < 4000) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        done_cyc = c;
        check("busy_at_done", busy, 1'b0);
        if (mode == 0) check("done_cycle", c, exp_done);
        if (fin_start) begin start = 1'b1; slot_mask = 32'hFFFF_FFFF; end
      end else begin
        check("busy_during", busy, 1'b1);
        @(posedge clk); #1;
        c++;
        bus.tx_ready = pick_ready(mode);
        if (busy_start && !injected && bus.tx_valid) begin
          start = 1'b1; slot_mask = ~mask; injected = 1'b1;
        end else begin
          start = 1'b0;
        end
      end
    end
    if (!seen) note_fail("done_timeout", c);
    @(posedge clk); #1;
    start = 1'b0; slot_mask = 32'h0;
    check("bytes_left", exp_bytes.size(), 0);
    check("reads_left", exp_addr.size(), 0);
    repeat (4) begin
      @(negedge clk);
      check("idle_busy", busy, 1'b0);
      check("idle_rd_en", bus.rd_en, 1'b0);
    end
    check("done_count", done_seen, d0 + 1);
    $display("dump mask=%08h mode=%0d bytes=%0d reads=%0d done_cycle=%0d",
             mask, mode, got_bytes.size(), got_addr.size(), done_cyc);
  endtask

  logic [7:0] lit2 [6];
  int dc;
  int d0r;
  bit seen_v;

  initial begin
    lit2[0] = 8'h02; lit2[1] = 8'h11; lit2[2] = 8'h22;
    lit2[3] = 8'h33; lit2[4] = 8'h44; lit2[5] = 8'h46;
    for (int i = 0; i < NUM_SLOTS; i++) store_mem[i] = $urandom;
    rst_n = 1'b0; start = 1'b0; slot_mask = 32'h0; bus.tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rd_en", bus.rd_en, 1'b0);
    check("rst_rd_addr", bus.rd_addr, 5'd0);
    check("rst_tx_valid", bus.tx_valid, 1'b0);
    check("rst_tx_data", bus.tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Reset while stalled in SEND
    store_mem[0] = 32'h0BAD_F00D;
    build_model(32'h1);
    d0r = done_seen;
    @(posedge clk); #1; start = 1'b1; slot_mask = 32'h1; bus.tx_ready = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    seen_v = 1'b0;
    for (int i = 0; i < 20 && !seen_v; i++) begin
      @(negedge clk);
      if (bus.tx_valid) seen_v = 1'b1;
    end
    check("rst_test_reached_send", seen_v, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_tx_valid", bus.tx_valid, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_rd_en", bus.rd_en, 1'b0);
    exp_bytes.delete(); exp_addr.delete();
    bus.tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      check("post_rst_tx_valid", bus.tx_valid, 1'b0);
      check("post_rst_done", done, 1'b0);
    end
    check("post_rst_no_done", done_seen, d0r);
    $display("reset mid-send: bytes_before_reset=%0d", got_bytes.size());

    // Single slot, then the same frame under backpressure
    store_mem[2] = 32'h4433_2211;
    for (int m = 0; m < 2; m++) begin
      run_dump(32'h4, m, 1'b0, 1'b0, dc);
      check("single_nbytes", got_bytes.size(), NB);
      for (int i = 0; i < NB; i++) check("single_lit", got_bytes[i], lit2[i]);
      check("single_nreads", got_addr.size(), 1);
      check("single_addr", got_addr[0], 5'd2);
    end

    // Empty mask
    run_dump(32'h0, 0, 1'b0, 1'b0, dc);
    check("empty_done_cycle", dc, 33);
    check("empty_bytes", got_bytes.size(), 0);
    check("empty_reads", got_addr.size(), 0);

    // Edge slots
    store_mem[0]  = 32'h0102_0304;
    store_mem[31] = 32'hA0B0_C0D0;
    run_dump(32'h8000_0001, 0, 1'b0, 1'b0, dc);
    check("edge_nreads", got_addr.size(), 2);
    check("edge_addr0", got_addr[0], 5'd0);
    check("edge_addr1", got_addr[1], 5'd31);
    check("edge_x0", got_bytes[1], 8'h04);
    check("edge_slot31", got_bytes[NB], 8'h1F);
    check("edge_x31", got_bytes[NB+1], 8'hD0);
    check("edge_t31", got_bytes[NB+4], 8'hA0);

    // Start while busy and in the FIN cycle are ignored; a later start works
    run_dump(32'h0000_0110, 1, 1'b1, 1'b1, dc);
    run_dump(32'h0000_0008, 0, 1'b0, 1'b0, dc);

    // Randomised dumps
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NUM_SLOTS; i++) store_mem[i] = $urandom;
      run_dump((k == 7) ? 32'hFFFF_FFFF : ($urandom & $urandom), k % 2, k[1], k[2], dc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
